// File: rtl/postage_stall_pkg.sv
// Shared constants and the per-channel blocked-condition function for the
// postage-filter AXI-Stream stall detector.
package postage_stall_pkg;

  localparam int DEF_NUM_CH       = 10;
  localparam int DEF_CNT_W        = 8;
  localparam int DEF_STALL_THRESH = 16;
  localparam int CH_IDX_W         = $clog2(DEF_NUM_CH);

  // Sink side is blocked when starved; source side is blocked when backpressured.
  function automatic logic ch_blocked(input logic is_input,
                                      input logic tvalid,
                                      input logic tready);
    return is_input ? (tready & ~tvalid) : (tvalid & ~tready);
  endfunction

endpackage

// File: rtl/postage_stall_chan_counter.sv
// One channel's saturating consecutive-stall counter and registered
// threshold flag.
module postage_stall_chan_counter
  import postage_stall_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int STALL_THRESH = DEF_STALL_THRESH,
  parameter bit IS_INPUT     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic tvalid,
  input  logic tready,
  output logic block
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(STALL_THRESH);

  logic [CNT_W-1:0] cnt_p0;
  logic [CNT_W-1:0] cnt_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    cnt_next = '0;
    if (en && ch_blocked(IS_INPUT, tvalid, tready))
      cnt_next = sat_inc(cnt_p0);
  end

  // Flag is registered from the next-state count so it rises on the
  // STALL_THRESH-th blocked edge and drops on the first unblocked edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_p0 <= '0;
      block  <= 1'b0;
    end else begin
      cnt_p0 <= cnt_next;
      block  <= (cnt_next >= THRESH_C);
    end
  end

endmodule

// File: rtl/postage_filter_axis_stall_detector.sv
// Per-channel AXI-Stream stall detector feeding the deadlock monitor.
// Optional sticky/first-channel status built when POSTAGE_STALL_STICKY_EN is defined.
module postage_filter_axis_stall_detector
  import postage_stall_pkg::*;
#(
  parameter int                NUM_CH       = DEF_NUM_CH,
  parameter int                CNT_W        = DEF_CNT_W,
  parameter int                STALL_THRESH = DEF_STALL_THRESH,
  parameter logic [NUM_CH-1:0] CH_IS_INPUT  = NUM_CH'(2'b11)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      en,
  input  logic [NUM_CH-1:0]         ch_tvalid,
  input  logic [NUM_CH-1:0]         ch_tready,
  output logic [NUM_CH-1:0]         axis_block_sigs,
  input  logic                      sticky_clr,
  output logic [NUM_CH-1:0]         stall_sticky,
  output logic [$clog2(NUM_CH)-1:0] first_ch,
  output logic                      first_vld
);

  localparam int IDX_W = $clog2(NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    postage_stall_chan_counter #(
      .CNT_W       (CNT_W),
      .STALL_THRESH(STALL_THRESH),
      .IS_INPUT    (CH_IS_INPUT[i])
    ) u_cnt (
      .clock (clock),
      .reset (reset),
      .en    (en),
      .tvalid(ch_tvalid[i]),
      .tready(ch_tready[i]),
      .block (axis_block_sigs[i])
    );
  end

`ifdef POSTAGE_STALL_STICKY_EN
  logic [NUM_CH-1:0] blk_d_p1;
  logic [NUM_CH-1:0] trip;
  logic              first_keep;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (v[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  assign trip       = axis_block_sigs & ~blk_d_p1;
  assign first_keep = first_vld & ~sticky_clr;

  // A trip coinciding with a clear is recorded after the clear is applied.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blk_d_p1     <= '0;
      stall_sticky <= '0;
      first_ch     <= '0;
      first_vld    <= 1'b0;
    end else begin
      blk_d_p1     <= axis_block_sigs;
      stall_sticky <= (sticky_clr ? '0 : stall_sticky) | trip;
      if (!first_keep && (|trip)) begin
        first_vld <= 1'b1;
        first_ch  <= lowest_idx(trip);
      end else begin
        first_vld <= first_keep;
      end
    end
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign stall_sticky      = '0;
  assign first_ch          = '0;
  assign first_vld         = 1'b0;
`endif

endmodule

// File: tb/tb_postage_filter_axis_stall_detector.sv
// Directed, table-driven bench for postage_filter_axis_stall_detector
// (default parameters; sticky expectations follow POSTAGE_STALL_STICKY_EN).
module tb_postage_filter_axis_stall_detector;

`ifdef POSTAGE_STALL_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic [9:0] ch_tvalid;
  logic [9:0] ch_tready;
  logic [9:0] axis_block_sigs;
  logic       sticky_clr;
  logic [9:0] stall_sticky;
  logic [3:0] first_ch;
  logic       first_vld;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  postage_filter_axis_stall_detector dut (
    .clock          (clock),
    .reset          (reset),
    .en             (en),
    .ch_tvalid      (ch_tvalid),
    .ch_tready      (ch_tready),
    .axis_block_sigs(axis_block_sigs),
    .sticky_clr     (sticky_clr),
    .stall_sticky   (stall_sticky),
    .first_ch       (first_ch),
    .first_vld      (first_vld)
  );

  typedef struct {
    string      name;
    logic       en;
    logic       clr;
    logic [9:0] tv;
    logic [9:0] tr;
    int         n;
    logic [9:0] exp_blk;
    logic [9:0] exp_stk;
    logic [3:0] exp_fc;
    logic       exp_fv;
  } vec_t;

  vec_t tbl[32];
  int   n_vec = 0;

  task automatic add(input string name, input logic e, input logic c,
                     input logic [9:0] tv, input logic [9:0] tr, input int n,
                     input logic [9:0] blk, input logic [9:0] stk,
                     input logic [3:0] fc, input logic fv);
    tbl[n_vec] = '{name, e, c, tv, tr, n, blk, stk, fc, fv};
    n_vec++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk10(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string name, input logic [9:0] stk,
                            input logic [3:0] fc, input logic fv);
    logic [9:0] e_stk;
    logic       e_fv;
    e_stk = STK ? stk : 10'h000;
    e_fv  = STK ? fv : 1'b0;
    chk10({name, " sticky"}, stall_sticky, e_stk);
    chk10({name, " first_vld"}, {9'd0, first_vld}, {9'd0, e_fv});
    if (e_fv)
      chk10({name, " first_ch"}, {6'd0, first_ch}, {6'd0, fc});
    else if (!STK)
      chk10({name, " first_ch"}, {6'd0, first_ch}, 10'h000);
  endtask

  initial begin
    bit sat_ok;
    bit en_ok;

    reset = 1'b1; en = 1'b0; sticky_clr = 1'b0;
    ch_tvalid = '0; ch_tready = '0;
    step(); step();
    chk10("reset blk", axis_block_sigs, 10'h000);
    chk_status("reset", 10'h000, 4'd0, 1'b0);
    reset = 1'b0; en = 1'b1;

    //   name         en clr tv       tr       n   blk      stk     fc fv
    add("idle",       1, 0, 10'h000, 10'h000, 3,  10'h000, 10'h000, 0, 0);
    add("ch5 15",     1, 0, 10'h020, 10'h000, 15, 10'h000, 10'h000, 0, 0);
    add("ch5 16",     1, 0, 10'h020, 10'h000, 1,  10'h020, 10'h000, 0, 0);
    add("ch5 17",     1, 0, 10'h020, 10'h000, 1,  10'h020, 10'h020, 5, 1);
    add("ch5 rdy",    1, 0, 10'h020, 10'h020, 1,  10'h000, 10'h020, 5, 1);
    add("clr only",   1, 1, 10'h000, 10'h000, 1,  10'h000, 10'h000, 0, 0);
    add("ch0 st15",   1, 0, 10'h000, 10'h001, 15, 10'h000, 10'h000, 0, 0);
    add("ch0 hs",     1, 0, 10'h001, 10'h001, 1,  10'h000, 10'h000, 0, 0);
    add("ch0 st15b",  1, 0, 10'h000, 10'h001, 15, 10'h000, 10'h000, 0, 0);
    add("idle2",      1, 0, 10'h000, 10'h000, 1,  10'h000, 10'h000, 0, 0);
    add("ch3+7 15",   1, 0, 10'h088, 10'h000, 15, 10'h000, 10'h000, 0, 0);
    add("ch3+7 16",   1, 0, 10'h088, 10'h000, 1,  10'h088, 10'h000, 0, 0);
    add("ch3+7 17",   1, 0, 10'h088, 10'h000, 1,  10'h088, 10'h088, 3, 1);
    add("idle3",      1, 0, 10'h000, 10'h000, 1,  10'h000, 10'h088, 3, 1);
    add("ch9 15",     1, 0, 10'h200, 10'h000, 15, 10'h000, 10'h088, 3, 1);
    add("ch9 16",     1, 0, 10'h200, 10'h000, 1,  10'h200, 10'h088, 3, 1);
    add("ch9 clr",    1, 1, 10'h200, 10'h000, 1,  10'h200, 10'h200, 9, 1);
    add("idle4",      1, 0, 10'h000, 10'h000, 1,  10'h000, 10'h200, 9, 1);
    add("en low",     0, 0, 10'h3FC, 10'h000, 20, 10'h000, 10'h200, 9, 1);
    add("clr2",       1, 1, 10'h000, 10'h000, 1,  10'h000, 10'h000, 0, 0);

    for (int i = 0; i < n_vec; i++) begin
      en = tbl[i].en; sticky_clr = tbl[i].clr;
      ch_tvalid = tbl[i].tv; ch_tready = tbl[i].tr;
      for (int k = 0; k < tbl[i].n; k++) step();
      chk10({tbl[i].name, " blk"}, axis_block_sigs, tbl[i].exp_blk);
      chk_status(tbl[i].name, tbl[i].exp_stk, tbl[i].exp_fc, tbl[i].exp_fv);
    end
    sticky_clr = 1'b0; en = 1'b1;

    // Long stall on ch4: flag must hold through counter saturation.
    ch_tvalid = 10'h010; ch_tready = '0;
    for (int k = 0; k < 15; k++) step();
    chk10("sat pre", axis_block_sigs, 10'h000);
    sat_ok = 1'b1;
    for (int k = 15; k < 300; k++) begin
      step();
      if (axis_block_sigs !== 10'h010) sat_ok = 1'b0;
    end
    chk10("sat hold", {9'd0, sat_ok}, 10'h001);
    ch_tvalid = '0;
    step();
    chk10("sat release", axis_block_sigs, 10'h000);

    // Reset in the middle of a stall restarts the count.
    ch_tvalid = 10'h040;
    for (int k = 0; k < 10; k++) step();
    reset = 1'b1;
    #1;
    chk10("midrst blk", axis_block_sigs, 10'h000);
    chk_status("midrst", 10'h000, 4'd0, 1'b0);
    step(); step();
    reset = 1'b0;
    for (int k = 0; k < 15; k++) step();
    chk10("postrst 15", axis_block_sigs, 10'h000);
    step();
    chk10("postrst 16", axis_block_sigs, 10'h040);

    // Enable held low for a long stall on every output channel.
    en = 1'b0; ch_tvalid = 10'h3FC;
    en_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (axis_block_sigs !== 10'h000) en_ok = 1'b0;
    end
    chk10("en0 hold", {9'd0, en_ok}, 10'h001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
